truth_table_sweeper: RTL and testbench

Sequential stimulus-and-capture stage wrapped around the combinational four-input / ten-output logic-function breadboard. It drives the breadboard's w,x,y,z inputs through all 16 codes, 0 to 15. For each code it waits a programmable settle time, then samples the ten function outputs. Each sample is streamed out over a valid/ready handshake and stored in a 16×10 capture table that can be read after the sweep. It replaces the hand-written delay-loop testbench with a synthesizable sweeper usable on hardware.

---
 rtl/truth_table_pkg.sv | 15 +
 rtl/tt_capture_ram.sv | 39 +++
 rtl/truth_table_sweeper.sv | 143 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper and its capture RAM.
package truth_table_pkg;

  localparam int NUM_CODES         = 16;
  localparam int CODE_W            = 4;
  localparam int DEFAULT_NUM_FUNCS = 10;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESULT,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/tt_capture_ram.sv
// 16-entry capture table: one write port, one combinational read port that
// returns the pre-write contents when reading the entry being written.
module tt_capture_ram
  import truth_table_pkg::*;
#(
  parameter int WIDTH = DEFAULT_NUM_FUNCS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [CODE_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [CODE_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [NUM_CODES];
  logic [WIDTH-1:0] mem_d [NUM_CODES];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input breadboard through codes 0..15, samples its outputs after a
// settle delay, streams each sample over valid/ready and keeps a capture table.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3,
  parameter int NUM_FUNCS     = DEFAULT_NUM_FUNCS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 w,
  output logic                 x,
  output logic                 y,
  output logic                 z,
  input  logic [NUM_FUNCS-1:0] f,
  output logic                 busy,
  output logic                 done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CODE_W-1:0]    res_idx,
  output logic [NUM_FUNCS-1:0] res_data,
  input  logic [CODE_W-1:0]    tbl_addr,
  output logic [NUM_FUNCS-1:0] tbl_data,
  output logic [7:0]           sweep_cnt
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE_CYCLES must be in 1..255");
    end
  endgenerate

  localparam logic [7:0]        SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [CODE_W-1:0] LAST_CODE     = CODE_W'(NUM_CODES - 1);

  sweep_state_t         state_q, state_d;
  logic [7:0]           settle_ctr_q, settle_ctr_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [CODE_W-1:0]    res_idx_q, res_idx_d;
  logic [NUM_FUNCS-1:0] res_data_q, res_data_d;
  logic [7:0]           sweep_cnt_q, sweep_cnt_d;
  logic                 capture;

  // Abort outranks both the settle expiry and the result handshake.
  always_comb begin
    state_d      = state_q;
    settle_ctr_d = settle_ctr_q;
    code_d       = code_q;
    res_idx_d    = res_idx_q;
    res_data_d   = res_data_q;
    sweep_cnt_d  = sweep_cnt_q;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        code_d = '0;
        if (start && !abort) begin
          state_d      = SETTLE;
          settle_ctr_d = SETTLE_RELOAD;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          code_d  = '0;
        end else if (settle_ctr_q == '0) begin
          capture    = 1'b1;
          res_data_d = f;
          res_idx_d  = code_q;
          state_d    = RESULT;
        end else begin
          settle_ctr_d = settle_ctr_q - 8'd1;
        end
      end
      RESULT: begin
        if (abort) begin
          state_d = IDLE;
          code_d  = '0;
        end else if (res_ready) begin
          if (code_q == LAST_CODE) begin
            state_d = DONE;
          end else begin
            code_d       = code_q + CODE_W'(1);
            settle_ctr_d = SETTLE_RELOAD;
            state_d      = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = '0;
        if (sweep_cnt_q != 8'hFF) begin
          sweep_cnt_d = sweep_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_ctr_q <= '0;
      code_q       <= '0;
      res_idx_q    <= '0;
      res_data_q   <= '0;
      sweep_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_ctr_q <= settle_ctr_d;
      code_q       <= code_d;
      res_idx_q    <= res_idx_d;
      res_data_q   <= res_data_d;
      sweep_cnt_q  <= sweep_cnt_d;
    end
  end

  tt_capture_ram #(
    .WIDTH(NUM_FUNCS)
  ) u_capture_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (capture),
    .waddr(code_q),
    .wdata(f),
    .raddr(tbl_addr),
    .rdata(tbl_data)
  );

  assign {w, x, y, z} = code_q;
  assign busy         = (state_q == SETTLE) || (state_q == RESULT);
  assign done         = (state_q == DONE);
  assign res_valid    = (state_q == RESULT);
  assign res_idx      = res_idx_q;
  assign res_data     = res_data_q;
  assign sweep_cnt    = sweep_cnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a lookup-table breadboard model.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       w, x, y, z;
  logic [9:0] f;
  logic       busy;
  logic       done;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_idx;
  logic [9:0] res_data;
  logic [3:0] tbl_addr;
  logic [9:0] tbl_data;
  logic [7:0] sweep_cnt;

  int checkCount = 0;
  int passCount  = 0;

  truth_table_sweeper #(
    .SETTLE_CYCLES(3),
    .NUM_FUNCS    (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .w        (w),
    .x        (x),
    .y        (y),
    .z        (z),
    .f        (f),
    .busy     (busy),
    .done     (done),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_idx  (res_idx),
    .res_data (res_data),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .sweep_cnt(sweep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-entered breadboard truth table; codes 0 and 15 match the known board.
  function automatic logic [9:0] breadboard(input logic [3:0] code);
    case (code)
      4'd0:    return 10'h194;
      4'd1:    return 10'h0A3;
      4'd2:    return 10'h1C5;
      4'd3:    return 10'h2F0;
      4'd4:    return 10'h04E;
      4'd5:    return 10'h3B1;
      4'd6:    return 10'h128;
      4'd7:    return 10'h2D7;
      4'd8:    return 10'h0F9;
      4'd9:    return 10'h33C;
      4'd10:   return 10'h18A;
      4'd11:   return 10'h055;
      4'd12:   return 10'h2A2;
      4'd13:   return 10'h3E1;
      4'd14:   return 10'h11F;
      default: return 10'h266;
    endcase
  endfunction

  always_comb f = breadboard({w, x, y, z});

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep from IDLE; optional stall on one index and a stray start pulse.
  task automatic applyStimulus(input int stallIdx, input int stallLen, input int pokeCycle,
                               input bit doChecks, output int doneCycle);
    int cyc    = 0;
    int stalls = 0;
    int expIdx = 0;
    bit hs;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!done && cyc < 3000) begin
      if (res_valid) begin
        if (doChecks) begin
          checkOutput("res_idx", 32'(res_idx), 32'(expIdx));
          checkOutput("res_data", 32'(res_data), 32'(breadboard(expIdx[3:0])));
          checkOutput("wxyz_hold", 32'({w, x, y, z}), 32'(expIdx));
        end
        if (int'(res_idx) == stallIdx && stalls < stallLen) begin
          res_ready = 1'b0;
          stalls++;
        end else begin
          res_ready = 1'b1;
        end
      end else begin
        res_ready = 1'b1;
      end
      if (doChecks) checkOutput("busy_run", 32'(busy), 32'd1);
      start = (cyc == pokeCycle);
      hs    = res_valid && res_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) expIdx++;
    end
    start     = 1'b0;
    res_ready = 1'b1;
    doneCycle = cyc;
    checkOutput("done_seen", 32'(done), 32'd1);
    if (doChecks) begin
      checkOutput("result_count", 32'(expIdx), 32'd16);
      checkOutput("busy_in_done", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  doneCycle;
    int  budget;
    bit  doneSeen;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    res_ready = 1'b1;
    tbl_addr  = 4'd0;
    applyReset();

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_wxyz", 32'({w, x, y, z}), 32'd0);
    checkOutput("rst_sweep_cnt", 32'(sweep_cnt), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_tbl0", 32'(tbl_data), 32'd0);

    $display("[TB] full sweep");
    applyStimulus(-1, 0, -1, 1'b1, doneCycle);
    checkOutput("full_done_cycle", 32'(doneCycle), 32'd64);
    checkOutput("full_sweep_cnt", 32'(sweep_cnt), 32'd1);
    checkOutput("full_done_low", 32'(done), 32'd0);
    checkOutput("full_wxyz_idle", 32'({w, x, y, z}), 32'd0);
    tbl_addr = 4'd0;
    #1;
    checkOutput("tbl_addr0", 32'(tbl_data), 32'h194);
    tbl_addr = 4'd15;
    #1;
    checkOutput("tbl_addr15", 32'(tbl_data), 32'h266);
    tbl_addr = 4'd6;
    #1;
    checkOutput("tbl_addr6", 32'(tbl_data), 32'h128);
    @(posedge clk);
    #1;

    $display("[TB] backpressure on idx 7");
    applyStimulus(7, 5, -1, 1'b1, doneCycle);
    checkOutput("bp_done_cycle", 32'(doneCycle), 32'd69);
    checkOutput("bp_sweep_cnt", 32'(sweep_cnt), 32'd2);

    $display("[TB] start while busy");
    applyStimulus(-1, 0, 20, 1'b1, doneCycle);
    checkOutput("poke_done_cycle", 32'(doneCycle), 32'd64);
    checkOutput("poke_sweep_cnt", 32'(sweep_cnt), 32'd3);

    $display("[TB] start/abort collision");
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("coll_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("coll_busy_later", 32'(busy), 32'd0);
    checkOutput("coll_valid_later", 32'(res_valid), 32'd0);
    checkOutput("coll_sweep_cnt", 32'(sweep_cnt), 32'd3);

    $display("[TB] reset mid-RESULT");
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    res_ready = 1'b0;
    budget    = 0;
    while (!res_valid && budget < 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput("pre_rst_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_valid", 32'(res_valid), 32'd0);
    checkOutput("arst_wxyz", 32'({w, x, y, z}), 32'd0);
    checkOutput("arst_res_idx", 32'(res_idx), 32'd0);
    checkOutput("arst_res_data", 32'(res_data), 32'd0);
    checkOutput("arst_sweep_cnt", 32'(sweep_cnt), 32'd0);
    for (int a = 0; a < 16; a++) begin
      tbl_addr = 4'(a);
      #1;
      checkOutput("arst_tbl", 32'(tbl_data), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] abort during SETTLE of idx 9");
    start     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    budget = 0;
    while (!({w, x, y, z} == 4'd9 && !res_valid) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput("abort_reached_idx9", 32'({w, x, y, z}), 32'd9);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_wxyz", 32'({w, x, y, z}), 32'd0);
    doneSeen = done;
    repeat (10) begin
      @(posedge clk);
      #1;
      doneSeen = doneSeen | done;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    checkOutput("abort_sweep_cnt", 32'(sweep_cnt), 32'd0);
    tbl_addr = 4'd8;
    #1;
    checkOutput("abort_tbl8", 32'(tbl_data), 32'h0F9);
    tbl_addr = 4'd9;
    #1;
    checkOutput("abort_tbl9", 32'(tbl_data), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] sweep counter saturation");
    for (int s = 0; s < 255; s++) begin
      applyStimulus(-1, 0, -1, 1'b0, doneCycle);
    end
    checkOutput("sat_cnt_255", 32'(sweep_cnt), 32'd255);
    applyStimulus(-1, 0, -1, 1'b0, doneCycle);
    checkOutput("sat_cnt_hold", 32'(sweep_cnt), 32'd255);
    checkOutput("sat_done_cycle", 32'(doneCycle), 32'd64);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
